// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with valid/ready handshakes on both sides.
// Single-cycle ops finish in one cycle; shifts iterate one bit per cycle.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] shreg_q;
  logic [4:0]       cnt_q;
  logic             dir_q;
  logic             accept;
  logic             is_shift;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] shift_next;

  // Shift codes fall through to passing A, which is the shamt==0 result.
  function automatic logic [WIDTH-1:0] alu_calc(input logic [2:0] op,
                                                input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic right);
    return right ? (v >> 1) : (v << 1);
  endfunction

  assign accept     = in_valid && (state_q == IDLE);
  assign is_shift   = (alu_control[2:1] == 2'b11);
  assign shamt      = src_b[4:0];
  assign shift_next = shift_one(shreg_q, dir_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != 5'd0)) state_d = SHIFT;
          else                             state_d = DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == 5'd1) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; the result is written on the cycle the op completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      shreg_q  <= '0;
      cnt_q    <= 5'd0;
      dir_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != 5'd0)) begin
              shreg_q <= src_a;
              cnt_q   <= shamt;
              dir_q   <= alu_control[0];
            end else begin
              result_q <= alu_calc(alu_control, src_a, src_b);
            end
          end
        end
        SHIFT: begin
          shreg_q <= shift_next;
          cnt_q   <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) result_q <= shift_next;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed results, latencies,
// back-pressure hold and reset abort behaviour.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int total = 0;
  int bad   = 0;
  int lat;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a request at a falling edge; it is accepted on the following rising edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    alu_control = 3'b000;
    src_a       = 32'hDEAD_BEEF;
    src_b       = 32'h0000_0003;
  endtask

  // Counts falling edges after acceptance until out_valid; bounded.
  task automatic wait_done(output int n);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    send(op, a, b);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
    consume();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 3'b000; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_result", result, 32'd0);

    run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("sub", 3'b001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run_op("slt_neg", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("slt_pos", 3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("and", 3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1);
    run_op("or", 3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1);
    run_op("xor", 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1);
    run_op("sll31", 3'b110, 32'd1, 32'd31, 32'h8000_0000, 32);
    run_op("srl0", 3'b111, 32'h8000_0000, 32'd0, 32'h8000_0000, 1);
    run_op("srl4", 3'b111, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, 5);
    run_op("sll3", 3'b110, 32'h0000_00F1, 32'd3, 32'h0000_0788, 4);

    // Back-pressure: result held in DONE while a new request is offered and ignored.
    send(3'b000, 32'd3, 32'd4);
    wait_done(lat);
    chk("hold_lat", 32'(lat), 32'd1);
    in_valid = 1'b1; alu_control = 3'b001; src_a = 32'd100; src_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, 32'd7);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    consume();
    chk("hold_result_kept", result, 32'd7);

    // Reset during SHIFT after 3 of 10 shift cycles.
    send(3'b110, 32'd1, 32'd10);
    repeat (3) @(negedge clk);
    chk("shift_out_valid", {31'd0, out_valid}, 32'd0);
    chk("shift_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) @(negedge clk);
    chk("abort_no_late_valid", {31'd0, out_valid}, 32'd0);

    // Reset has priority over a simultaneous request.
    run_op("pre_prio", 3'b000, 32'd2, 32'd2, 32'd4, 1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; alu_control = 3'b000; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("prio_out_valid", {31'd0, out_valid}, 32'd0);
    chk("prio_in_ready", {31'd0, in_ready}, 32'd1);
    chk("prio_result", result, 32'd0);

    run_op("post_rst_add", 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  the operation request is valid.
REQ-005 SHALL have port in_ready  output  1  the unit accepts a request this cycle.
REQ-006 SHALL have port alu_control  input  3  the operation code from the ALU decoder.
REQ-007 SHALL have port src_a  input  WIDTH  operand A.
REQ-008 SHALL have port src_b  input  WIDTH  operand B; bits [4:0] are the shift amount for shifts.
REQ-009 SHALL have port out_valid  output  1  result and zero are valid.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-011 SHALL have port result  output  WIDTH  the registered operation result.
REQ-012 SHALL have port zero  output  1  asserted when result equals 0; used for beq.

Function
REQ-013 SHALL decode alu_control as: 000 add, 001 sub (A-B), 010 and, 011 or, 100 xor, 101 slt signed, 110 sll, 111 srl logical.
REQ-014 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid and in_ready are both 1.
REQ-016 SHALL ignore alu_control, src_a and src_b on all cycles without acceptance.
REQ-017 SHALL, on accepting a non-shift code, register the result and enter DONE, so out_valid rises 1 cycle after acceptance.
REQ-018 SHALL compute add and sub modulo 2^WIDTH, discarding carry and borrow.
REQ-019 SHALL make slt produce 1 when A<B as two's complement, else 0, zero-extended to WIDTH.
REQ-020 SHALL, on accepting sll or srl with shamt=src_b[4:0]=0, load A unchanged and enter DONE (1-cycle latency).
REQ-021 SHALL, on accepting sll or srl with shamt>0, load A and shamt into internal registers and enter SHIFT.
REQ-022 SHALL, in SHIFT, shift the working register by 1 bit per cycle (zero fill) and decrement the count.
REQ-023 SHALL leave SHIFT for DONE in the cycle the count reaches 0; total latency is 1+shamt cycles (max 32).
REQ-024 SHALL hold out_valid=1 with result and zero stable in DONE until out_ready=1.
REQ-025 SHALL return to IDLE on the DONE cycle with out_ready=1; in_ready then rises the next cycle (no same-cycle overlap).
REQ-026 SHALL keep out_valid=0 in IDLE and SHIFT; a value of out_ready in those states SHALL have no effect.
REQ-027 SHALL compute zero combinationally from the registered result.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, enter IDLE and clear result, the shift register and the count to 0.
REQ-029 SHALL therefore output out_valid=0, in_ready=1 and zero=1 after reset.
REQ-030 SHALL abort an operation on rst in SHIFT or DONE, with no result delivered.
REQ-031 SHALL give rst priority over in_valid in the same cycle; the request is not accepted.

Verification
REQ-032 SHALL check: add A=0xFFFFFFFF, B=1 -> 1 cycle later out_valid=1, result=0, zero=1.
REQ-033 SHALL check: sub A=5, B=7 -> result 0xFFFFFFFE, zero=0; slt A=0xFFFFFFFF, B=1 -> result 1.
REQ-034 SHALL check: sll A=1, B=31 -> out_valid after exactly 32 cycles, result 0x80000000; srl A=0x80000000, B=0 -> result 0x80000000 after 1 cycle.
REQ-035 SHALL check: DONE with out_ready=0 for 5 cycles -> result stable, in_ready=0; new in_valid is ignored.
REQ-036 SHALL check: rst asserted in SHIFT after 3 of 10 cycles -> next cycle IDLE, out_valid=0, result=0, in_ready=1.
REQ-037 SHALL check: and/or/xor of 0xF0F0F0F0 and 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00.
